// File: rtl/riscv_tb_pkg.sv
// Shared types and constants for the init/stimulus responder: FSM state type,
// word and address widths, and the preload address legality check.
package riscv_tb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ADDR_W     = 32;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    RUN   = 2'd3
  } init_state_e;

  // A preload byte address is usable when word aligned and inside [0, 4*depth).
  function automatic logic word_addr_ok(input logic [ADDR_W-1:0] addr,
                                        input int unsigned depth);
    logic [ADDR_W+1:0] limit;
    limit = (ADDR_W+2)'(depth) << 2;
    return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
  endfunction

endpackage

// File: rtl/riscv_init_responder_if.sv
// Bench-side init/stimulus bundle: preload write requests in, regfile debug
// read data back out.
interface riscv_init_responder_if #(
  parameter int XLEN       = riscv_tb_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_tb_pkg::REG_ADDR_W
);
  logic                  init_mem;
  logic [31:0]           init_addr;
  logic [XLEN-1:0]       init_data;
  logic                  imem_write;
  logic [31:0]           imem_addr;
  logic [XLEN-1:0]       imem_wdata;
  logic [REG_ADDR_W-1:0] rf_raddr1;
  logic [REG_ADDR_W-1:0] rf_raddr2;
  logic [XLEN-1:0]       rf_rdata1;
  logic [XLEN-1:0]       rf_rdata2;

  modport master (
    output init_mem, init_addr, init_data,
    output imem_write, imem_addr, imem_wdata,
    output rf_raddr1, rf_raddr2,
    input  rf_rdata1, rf_rdata2
  );

  modport slave (
    input  init_mem, init_addr, init_data,
    input  imem_write, imem_addr, imem_wdata,
    input  rf_raddr1, rf_raddr2,
    output rf_rdata1, rf_rdata2
  );
endinterface

// File: rtl/riscv_init_wr_stage.sv
// One preload write port: legality check on the byte address, then a single
// registered write toward the memory. Illegal requests raise drop for one cycle.
module riscv_init_wr_stage
  import riscv_tb_pkg::*;
#(
  parameter int XLEN  = riscv_tb_pkg::XLEN,
  parameter int DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              allow,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   data,
  output logic              we,
  output logic [IDX_W-1:0]  idx,
  output logic [XLEN-1:0]   wdat,
  output logic              drop
);

  localparam int unsigned DEPTH_U = DEPTH;

  logic             accept;
  logic             we_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [XLEN-1:0]  wdat_reg;

  assign accept = req & allow & word_addr_ok(addr, DEPTH_U);
  assign drop   = req & ~accept;

  // Reset clears the pending write so nothing lands after a mid-load reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_reg   <= 1'b0;
      idx_reg  <= '0;
      wdat_reg <= '0;
    end else begin
      we_reg <= accept;
      if (accept) begin
        idx_reg  <= addr[IDX_W+1:2];
        wdat_reg <= data;
      end
    end
  end

  assign we   = we_reg;
  assign idx  = idx_reg;
  assign wdat = wdat_reg;

endmodule

// File: rtl/riscv_init_responder.sv
// DUT-side responder for the bench init interface: sequences memory preload,
// holds the core until loading drains, and serves regfile debug reads.
module riscv_init_responder
  import riscv_tb_pkg::*;
#(
  parameter int XLEN       = riscv_tb_pkg::XLEN,
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024,
  parameter int ERR_W      = 8,
  localparam int IMEM_IDX_W = $clog2(IMEM_DEPTH),
  localparam int DMEM_IDX_W = $clog2(DMEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  riscv_init_responder_if.slave bus,
  output logic                  core_imem_we,
  output logic [IMEM_IDX_W-1:0] core_imem_widx,
  output logic [XLEN-1:0]       core_imem_wdat,
  output logic                  core_dmem_we,
  output logic [DMEM_IDX_W-1:0] core_dmem_widx,
  output logic [XLEN-1:0]       core_dmem_wdat,
  output logic [REG_ADDR_W-1:0] core_rf_addr1,
  output logic [REG_ADDR_W-1:0] core_rf_addr2,
  input  logic [XLEN-1:0]       core_rf_data1,
  input  logic [XLEN-1:0]       core_rf_data2,
  output logic                  core_hold,
  output logic                  load_done,
  output logic [ERR_W-1:0]      err_count
);

  init_state_e state_reg, state_next;
  logic        in_load;
  logic        imem_drop, dmem_drop;
  logic        load_done_reg;
  logic [ERR_W-1:0] err_reg, err_next;
  logic [1:0]       drop_sum;
  logic [ERR_W:0]   err_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= HOLD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HOLD:    if (bus.init_mem)  state_next = LOAD;
      LOAD:    if (!bus.init_mem) state_next = DRAIN;
      DRAIN:                      state_next = RUN;
      RUN:     if (bus.init_mem)  state_next = LOAD;
      default:                    state_next = HOLD;
    endcase
  end

  assign in_load = (state_reg == LOAD);

  // A reload request stalls the core immediately, before the FSM leaves RUN.
  assign core_hold = (state_reg != RUN) | bus.init_mem;

  riscv_init_wr_stage #(
    .XLEN  (XLEN),
    .DEPTH (IMEM_DEPTH)
  ) u_imem_wr (
    .clk   (clk),
    .reset (reset),
    .req   (bus.imem_write),
    .allow (in_load),
    .addr  (bus.imem_addr),
    .data  (bus.imem_wdata),
    .we    (core_imem_we),
    .idx   (core_imem_widx),
    .wdat  (core_imem_wdat),
    .drop  (imem_drop)
  );

  // The dmem port only exists while loading, so it never drops for timing.
  riscv_init_wr_stage #(
    .XLEN  (XLEN),
    .DEPTH (DMEM_DEPTH)
  ) u_dmem_wr (
    .clk   (clk),
    .reset (reset),
    .req   (bus.init_mem & in_load),
    .allow (1'b1),
    .addr  (bus.init_addr),
    .data  (bus.init_data),
    .we    (core_dmem_we),
    .idx   (core_dmem_widx),
    .wdat  (core_dmem_wdat),
    .drop  (dmem_drop)
  );

  assign drop_sum = {1'b0, imem_drop} + {1'b0, dmem_drop};
  assign err_sum  = {1'b0, err_reg} + {{(ERR_W-1){1'b0}}, drop_sum};
  assign err_next = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_reg       <= '0;
      load_done_reg <= 1'b0;
    end else begin
      err_reg       <= err_next;
      load_done_reg <= (state_reg == DRAIN);
    end
  end

  assign err_count = err_reg;
  assign load_done = load_done_reg;

  // Debug read ports: address passes straight through, data is registered.
  logic [REG_ADDR_W-1:0] rf_raddr [2];
  logic [XLEN-1:0]       rf_core  [2];

  assign rf_raddr[0]   = bus.rf_raddr1;
  assign rf_raddr[1]   = bus.rf_raddr2;
  assign rf_core[0]    = core_rf_data1;
  assign rf_core[1]    = core_rf_data2;
  assign core_rf_addr1 = bus.rf_raddr1;
  assign core_rf_addr2 = bus.rf_raddr2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rf
      logic [XLEN-1:0] rdata_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdata_reg <= '0;
        end else begin
          rdata_reg <= (rf_raddr[gi] == '0) ? '0 : rf_core[gi];
        end
      end
    end
  endgenerate

  assign bus.rf_rdata1 = g_rf[0].rdata_reg;
  assign bus.rf_rdata2 = g_rf[1].rdata_reg;

endmodule

// File: tb/tb_riscv_init_responder.sv
// Randomized bench for riscv_init_responder against a behavioural model of the
// load/drain/run sequencing, drop accounting and debug reads.
module tb_riscv_init_responder;

  localparam int XLEN       = 32;
  localparam int IMEM_DEPTH = 1024;
  localparam int DMEM_DEPTH = 512;
  localparam int ERR_W      = 8;
  localparam int ERR_MAX    = 255;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  riscv_init_responder_if #(.XLEN(XLEN), .REG_ADDR_W(5)) bus ();

  logic            core_imem_we;
  logic [9:0]      core_imem_widx;
  logic [XLEN-1:0] core_imem_wdat;
  logic            core_dmem_we;
  logic [8:0]      core_dmem_widx;
  logic [XLEN-1:0] core_dmem_wdat;
  logic [4:0]      core_rf_addr1, core_rf_addr2;
  logic [XLEN-1:0] core_rf_data1, core_rf_data2;
  logic            core_hold, load_done;
  logic [ERR_W-1:0] err_count;

  // Regfile stand-in answering the debug read ports combinationally.
  logic [XLEN-1:0] rf_model [32];
  assign core_rf_data1 = rf_model[core_rf_addr1];
  assign core_rf_data2 = rf_model[core_rf_addr2];

  riscv_init_responder #(
    .XLEN       (XLEN),
    .IMEM_DEPTH (IMEM_DEPTH),
    .DMEM_DEPTH (DMEM_DEPTH),
    .ERR_W      (ERR_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .core_imem_we   (core_imem_we),
    .core_imem_widx (core_imem_widx),
    .core_imem_wdat (core_imem_wdat),
    .core_dmem_we   (core_dmem_we),
    .core_dmem_widx (core_dmem_widx),
    .core_dmem_wdat (core_dmem_wdat),
    .core_rf_addr1  (core_rf_addr1),
    .core_rf_addr2  (core_rf_addr2),
    .core_rf_data1  (core_rf_data1),
    .core_rf_data2  (core_rf_data2),
    .core_hold      (core_hold),
    .load_done      (load_done),
    .err_count      (err_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: which phase of the load sequence we are in, and the drop tally.
  bit m_loading  = 0;
  bit m_draining = 0;
  bit m_running  = 0;
  int m_err      = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a, input int depth);
    return (a % 4 == 0) && (longint'(a) < 4 * longint'(depth));
  endfunction

  function automatic logic [31:0] rand_addr(input int depth);
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'(4 * $urandom_range(0, depth - 1) + $urandom_range(1, 3));
    if (r == 1) return 32'(4 * depth + 4 * $urandom_range(0, 100));
    if (r == 2) return 32'hFFFF_FFFC;
    return 32'(4 * $urandom_range(0, depth - 1));
  endfunction

  task automatic drive_idle();
    bus.init_mem   = 1'b0;
    bus.init_addr  = '0;
    bus.init_data  = '0;
    bus.imem_write = 1'b0;
    bus.imem_addr  = '0;
    bus.imem_wdata = '0;
    bus.rf_raddr1  = '0;
    bus.rf_raddr2  = '0;
  endtask

  task automatic model_reset();
    m_loading  = 0;
    m_draining = 0;
    m_running  = 0;
    m_err      = 0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(input string what);
    bit exp_iwe, exp_dwe, exp_done, drop_i, drop_d;
    logic [31:0] iaddr, idata, daddr, ddata, exp_rd1, exp_rd2;
    check("rf_addr1_pass", 64'(core_rf_addr1), 64'(bus.rf_raddr1));
    check("rf_addr2_pass", 64'(core_rf_addr2), 64'(bus.rf_raddr2));
    iaddr = bus.imem_addr;
    idata = bus.imem_wdata;
    daddr = bus.init_addr;
    ddata = bus.init_data;
    exp_iwe  = m_loading && bus.imem_write && addr_ok(iaddr, IMEM_DEPTH);
    drop_i   = bus.imem_write && !exp_iwe;
    exp_dwe  = m_loading && bus.init_mem && addr_ok(daddr, DMEM_DEPTH);
    drop_d   = m_loading && bus.init_mem && !exp_dwe;
    exp_rd1  = (bus.rf_raddr1 == 0) ? 32'h0 : rf_model[bus.rf_raddr1];
    exp_rd2  = (bus.rf_raddr2 == 0) ? 32'h0 : rf_model[bus.rf_raddr2];
    exp_done = m_draining;
    if (m_draining) begin
      m_draining = 0;
      m_running  = 1;
    end else if (m_loading) begin
      if (!bus.init_mem) begin
        m_loading  = 0;
        m_draining = 1;
      end
    end else if (bus.init_mem) begin
      m_running = 0;
      m_loading = 1;
    end
    m_err = m_err + int'(drop_i) + int'(drop_d);
    if (m_err > ERR_MAX) m_err = ERR_MAX;

    @(posedge clk);
    #1;
    check("imem_we", 64'(core_imem_we), 64'(exp_iwe));
    if (exp_iwe) begin
      check("imem_idx", 64'(core_imem_widx), 64'(iaddr >> 2));
      check("imem_wdat", 64'(core_imem_wdat), 64'(idata));
    end
    check("dmem_we", 64'(core_dmem_we), 64'(exp_dwe));
    if (exp_dwe) begin
      check("dmem_idx", 64'(core_dmem_widx), 64'(daddr >> 2));
      check("dmem_wdat", 64'(core_dmem_wdat), 64'(ddata));
    end
    check("err_count", 64'(err_count), 64'(m_err));
    check("load_done", 64'(load_done), 64'(exp_done));
    check("core_hold", 64'(core_hold), 64'(!m_running || bus.init_mem));
    check("rf_rdata1", 64'(bus.rf_rdata1), 64'(exp_rd1));
    check("rf_rdata2", 64'(bus.rf_rdata2), 64'(exp_rd2));
    $display("txn %-8s init=%0b iw=%0b iwe=%0b didx=%0d dwe=%0b hold=%0b done=%0b err=%0d",
             what, bus.init_mem, bus.imem_write, core_imem_we, core_dmem_widx,
             core_dmem_we, core_hold, load_done, err_count);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hold"}, 64'(core_hold), 64'd1);
    check({tag, "_imem_we"}, 64'(core_imem_we), 64'd0);
    check({tag, "_dmem_we"}, 64'(core_dmem_we), 64'd0);
    check({tag, "_done"}, 64'(load_done), 64'd0);
    check({tag, "_err"}, 64'(err_count), 64'd0);
    check({tag, "_rd1"}, 64'(bus.rf_rdata1), 64'd0);
    check({tag, "_rd2"}, 64'(bus.rf_rdata2), 64'd0);
  endtask

  // Called at a falling edge; holds reset across one rising edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    $display("txn reset");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = $urandom;
    drive_idle();
    @(negedge clk);
    do_reset();

    // Basic load: four imem writes alongside dmem writes, then release.
    bus.init_mem = 1'b1;
    step("enter");
    for (int i = 0; i < 4; i++) begin
      bus.imem_write = 1'b1;
      bus.imem_addr  = 32'(4 * i);
      bus.imem_wdata = $urandom;
      bus.init_addr  = 32'(4 * i + 32'h100);
      bus.init_data  = $urandom;
      step("load");
    end
    bus.imem_write = 1'b0;
    bus.init_mem   = 1'b0;
    step("drain");
    step("run");
    step("run");

    // Reload, then misaligned and out-of-range imem addresses.
    bus.init_mem  = 1'b1;
    bus.init_addr = 32'h0000_0040;
    step("reload");
    bus.imem_write = 1'b1;
    bus.imem_addr  = 32'h0000_0002;
    step("bad_mis");
    bus.imem_addr  = 32'h0000_1000;
    step("bad_oob");

    // Simultaneous imem and dmem writes.
    bus.imem_addr  = 32'h0000_0010;
    bus.imem_wdata = 32'h0BAD_F00D;
    bus.init_addr  = 32'h0000_0020;
    bus.init_data  = 32'hDEAD_BEEF;
    step("simul");
    bus.imem_write = 1'b0;
    bus.init_mem   = 1'b0;
    step("drain");
    step("run");

    // imem write while running is dropped and does not stall the core.
    bus.imem_write = 1'b1;
    bus.imem_addr  = 32'h0000_0000;
    step("run_wr");
    bus.imem_write = 1'b0;

    // Debug reads, including the hardwired-zero register.
    rf_model[5]   = 32'h0000_1234;
    rf_model[0]   = 32'hFFFF_FFFF;
    bus.rf_raddr1 = 5'd5;
    bus.rf_raddr2 = 5'd0;
    step("rf_read");

    // Both ports dropping every cycle drives the counter into saturation.
    bus.init_mem = 1'b1;
    step("reload");
    bus.imem_write = 1'b1;
    bus.imem_addr  = 32'h0000_0003;
    bus.init_addr  = 32'h0000_7FF0;
    for (int i = 0; i < 140; i++) step("sat");
    bus.imem_write = 1'b0;
    bus.init_mem   = 1'b0;
    step("drain");
    step("run");

    // Reset while a registered write is in flight.
    bus.init_mem = 1'b1;
    bus.init_addr = 32'h0000_0040;
    step("reload");
    bus.imem_write = 1'b1;
    bus.imem_addr  = 32'h0000_0008;
    bus.imem_wdata = 32'h1111_2222;
    bus.init_addr  = 32'h0000_0044;
    @(posedge clk);
    #1;
    check("midrst_pre_imem_we", 64'(core_imem_we), 64'd1);
    check("midrst_pre_dmem_idx", 64'(core_dmem_widx), 64'd17);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_reset_outputs("midrst_held");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drive_idle();
    $display("txn reset_mid_load");
    step("hold");
    step("hold");

    // Randomized traffic across all phases with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) bus.init_mem = ~bus.init_mem;
      bus.imem_write = 1'($urandom_range(0, 1));
      bus.imem_addr  = rand_addr(IMEM_DEPTH);
      bus.imem_wdata = $urandom;
      bus.init_addr  = rand_addr(DMEM_DEPTH);
      bus.init_data  = $urandom;
      bus.rf_raddr1  = 5'($urandom_range(0, 31));
      bus.rf_raddr2  = 5'($urandom_range(0, 31));
      rf_model[$urandom_range(0, 31)] = $urandom;
      if ($urandom_range(0, 299) == 0) do_reset();
      else step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
